snake_game_ctrl: RTL and testbench

Game-level sequencer for the snake datapath. Converts the once-per-frame tick into movement `update` pulses and runs the game state machine (`START`, `PLAY`, `PAUSE`, `GAME_OVER`). Filters player direction requests, counts apples into a score, and drives `game_state`, `direction` and `update` into the snake drawing block. Sits between input synchronisers/VGA timing and the snake/apple datapath.

---
 rtl/snake_game_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, step timing, direction filter and apple scoring for the snake datapath.
// Optional build macro SNAKE_SPEEDUP_EN shortens the step period as apples are collected.
module snake_game_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned MIN_FRAMES      = 2,
  parameter int unsigned SPEEDUP_EVERY   = 4,
  parameter int unsigned GAMEOVER_FRAMES = 120,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [2:0]         dir_in,
  input  logic [1:0]         collision,
  output logic [1:0]         game_state,
  output logic [2:0]         direction,
  output logic               update,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned PER_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned GO_W  = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  // Elaboration-time parameter sanity checks.
  if (FRAMES_PER_STEP < 2) begin : g_bad_fps
    $error("FRAMES_PER_STEP must be at least 2");
  end
  if (MIN_FRAMES < 1 || MIN_FRAMES > FRAMES_PER_STEP) begin : g_bad_min
    $error("MIN_FRAMES must lie in 1..FRAMES_PER_STEP");
  end
  if (SPEEDUP_EVERY < 1) begin : g_bad_every
    $error("SPEEDUP_EVERY must be at least 1");
  end
  if (GAMEOVER_FRAMES < 1) begin : g_bad_go
    $error("GAMEOVER_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [GO_W-1:0]    go_cnt_q, go_cnt_d;
  logic               update_q, update_d;
  logic [2:0]         dir_q, dir_d;
  logic [2:0]         pending_q, pending_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_prev_q, start_prev_d;
  logic               apple_prev_q, apple_prev_d;

  logic               start_edge_c;
  logic               apple_c;
  logic               apple_edge_c;
  logic               wall_c;
  logic               dir_ok_c;
  logic [PER_W-1:0]   period_c;
  logic               step_due_c;

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

`ifdef SNAKE_SPEEDUP_EN
  localparam int unsigned APL_W     = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam int unsigned MAX_SPEED = FRAMES_PER_STEP - MIN_FRAMES;

  logic [PER_W-1:0] speed_q, speed_d;
  logic [APL_W-1:0] apple_mod_q, apple_mod_d;

  // Speed level is capped so the period never drops below MIN_FRAMES.
  assign period_c = PER_W'(FRAMES_PER_STEP) - speed_q;
`else
  assign period_c = PER_W'(FRAMES_PER_STEP);
`endif

  assign start_edge_c = start_btn & ~start_prev_q;
  assign apple_c      = (collision == 2'b10);
  assign apple_edge_c = apple_c & ~apple_prev_q;
  assign wall_c       = (collision == 2'b01);
  assign dir_ok_c     = (dir_in >= DIR_UP) && (dir_in <= DIR_RIGHT) && (dir_in != reverse_of(dir_q));
  // A count at or past the last frame of a (possibly shrunk) period completes the step.
  assign step_due_c   = (PER_W'(frame_cnt_q) >= (period_c - PER_W'(1)));

  always_comb begin
    logic clr_game;
    clr_game     = 1'b0;
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    go_cnt_d     = go_cnt_q;
    update_d     = 1'b0;
    dir_d        = dir_q;
    pending_d    = pending_q;
    score_d      = score_q;
    start_prev_d = start_btn;
    apple_prev_d = apple_c;
`ifdef SNAKE_SPEEDUP_EN
    speed_d      = speed_q;
    apple_mod_d  = apple_mod_q;
`endif

    if (dir_ok_c) pending_d = dir_in;

    case (state_q)
      ST_START: begin
        if (start_edge_c) begin
          state_d  = ST_PLAY;
          clr_game = 1'b1;
        end
      end
      ST_PLAY: begin
        if (apple_edge_c) begin
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
`ifdef SNAKE_SPEEDUP_EN
          if (apple_mod_q == APL_W'(SPEEDUP_EVERY - 1)) begin
            apple_mod_d = '0;
            if (speed_q < PER_W'(MAX_SPEED)) speed_d = speed_q + PER_W'(1);
          end else begin
            apple_mod_d = apple_mod_q + APL_W'(1);
          end
`endif
        end
        if (wall_c) begin
          state_d  = ST_OVER;
          go_cnt_d = '0;
        end else begin
          if (start_edge_c) state_d = ST_PAUSE;
          if (frame_tick) begin
            if (step_due_c) begin
              update_d    = 1'b1;
              frame_cnt_d = '0;
              if (pending_d != DIR_NONE) dir_d = pending_d;
              pending_d   = DIR_NONE;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_PAUSE: begin
        if (start_edge_c) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (go_cnt_q == GO_W'(GAMEOVER_FRAMES - 1)) begin
            state_d  = ST_START;
            go_cnt_d = '0;
            clr_game = 1'b1;
          end else begin
            go_cnt_d = go_cnt_q + GO_W'(1);
          end
        end
      end
      default: state_d = ST_START;
    endcase

    // Fresh game context on entry to START and on leaving START for PLAY.
    if (clr_game) begin
      score_d     = '0;
      frame_cnt_d = '0;
      dir_d       = DIR_RIGHT;
      pending_d   = DIR_NONE;
`ifdef SNAKE_SPEEDUP_EN
      speed_d     = '0;
      apple_mod_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_START;
      frame_cnt_q  <= '0;
      go_cnt_q     <= '0;
      update_q     <= 1'b0;
      dir_q        <= DIR_NONE;
      pending_q    <= DIR_NONE;
      score_q      <= '0;
      start_prev_q <= 1'b0;
      apple_prev_q <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      speed_q      <= '0;
      apple_mod_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      go_cnt_q     <= go_cnt_d;
      update_q     <= update_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      score_q      <= score_d;
      start_prev_q <= start_prev_d;
      apple_prev_q <= apple_prev_d;
`ifdef SNAKE_SPEEDUP_EN
      speed_q      <= speed_d;
      apple_mod_q  <= apple_mod_d;
`endif
    end
  end

  assign game_state = state_q;
  assign direction  = dir_q;
  assign update     = update_q;
  assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed and randomized checks of snake_game_ctrl against a rule-level game model.
module tb_snake_game_ctrl;

  localparam int unsigned FPS       = 8;
  localparam int unsigned MINF      = 2;
  localparam int unsigned SPEEDUP   = 4;
  localparam int unsigned GO_FRAMES = 120;
  localparam int unsigned SW        = 8;
  localparam int          MAX_SCORE = (1 << SW) - 1;

  localparam int S_START = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_OVER  = 3;

`ifdef SNAKE_SPEEDUP_EN
  localparam int EXP_P_AFTER4 = 7;
`else
  localparam int EXP_P_AFTER4 = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          start_btn;
  logic [2:0]    dir_in;
  logic [1:0]    collision;
  logic [1:0]    game_state;
  logic [2:0]    direction;
  logic          update;
  logic [SW-1:0] score;

  int errors = 0;
  int checks = 0;

  // Reference game model: plain integers following the game rules.
  int m_state, m_dir, m_pend, m_score, m_apples, m_fc, m_go;
  bit m_upd, m_sb_prev, m_ap_prev;

  snake_game_ctrl #(
    .FRAMES_PER_STEP (FPS),
    .MIN_FRAMES      (MINF),
    .SPEEDUP_EVERY   (SPEEDUP),
    .GAMEOVER_FRAMES (GO_FRAMES),
    .SCORE_W         (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .dir_in     (dir_in),
    .collision  (collision),
    .game_state (game_state),
    .direction  (direction),
    .update     (update),
    .score      (score)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int opposite(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int period_now();
`ifdef SNAKE_SPEEDUP_EN
    int p;
    p = int'(FPS) - m_apples / int'(SPEEDUP);
    return (p < int'(MINF)) ? int'(MINF) : p;
`else
    return int'(FPS);
`endif
  endfunction

  task automatic model_reset();
    m_state = S_START; m_dir = 0; m_pend = 0; m_score = 0; m_apples = 0;
    m_fc = 0; m_go = 0; m_upd = 0; m_sb_prev = 0; m_ap_prev = 0;
  endtask

  task automatic new_game();
    m_score = 0; m_apples = 0; m_fc = 0; m_dir = 4; m_pend = 0;
  endtask

  task automatic model_step(input logic ft, input logic sb, input logic [2:0] di, input logic [1:0] co);
    bit sb_edge, apple, ap_edge, wall;
    int nstate, p, req;
    sb_edge = sb && !m_sb_prev;
    apple   = (co == 2'b10);
    ap_edge = apple && !m_ap_prev;
    wall    = (co == 2'b01);
    req     = int'(di);
    nstate  = m_state;
    p       = period_now();
    m_upd   = 0;
    if (req >= 1 && req <= 4 && req != opposite(m_dir)) m_pend = req;
    case (m_state)
      S_START: if (sb_edge) begin new_game(); nstate = S_PLAY; end
      S_PLAY: begin
        if (ap_edge) begin
          if (m_score < MAX_SCORE) m_score++;
          m_apples++;
        end
        if (wall) begin
          nstate = S_OVER;
          m_go = 0;
        end else begin
          if (sb_edge) nstate = S_PAUSE;
          if (ft) begin
            m_fc++;
            if (m_fc >= p) begin
              m_upd = 1;
              m_fc = 0;
              if (m_pend != 0) m_dir = m_pend;
              m_pend = 0;
            end
          end
        end
      end
      S_PAUSE: if (sb_edge) nstate = S_PLAY;
      default: begin
        if (ft) begin
          m_go++;
          if (m_go == int'(GO_FRAMES)) begin
            nstate = S_START;
            m_go = 0;
            new_game();
          end
        end
      end
    endcase
    m_sb_prev = sb;
    m_ap_prev = apple;
    m_state   = nstate;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("game_state", 32'(game_state), 32'(m_state));
    chk("direction",  32'(direction),  32'(m_dir));
    chk("update",     32'(update),     32'(m_upd));
    chk("score",      32'(score),      32'(m_score));
  endtask

  task automatic cyc(input logic ft, input logic sb, input logic [2:0] di, input logic [1:0] co);
    frame_tick = ft; start_btn = sb; dir_in = di; collision = co;
    model_step(ft, sb, di, co);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 3'd0, 2'b00);
    idle();
  endtask

  task automatic press();
    cyc(1'b0, 1'b1, 3'd0, 2'b00);
    idle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},  32'(game_state), 32'd0);
    chk({tag, "_dir"},    32'(direction),  32'd0);
    chk({tag, "_update"}, 32'(update),     32'd0);
    chk({tag, "_score"},  32'(score),      32'd0);
  endtask

  initial begin
    int n_upd, n, seen, r;
    logic sb_lvl, ft;
    logic [2:0] di;
    logic [1:0] co;

    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; dir_in = 3'd0; collision = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    idle();

    // 1: start and step cadence
    press();
    chk("t1_state", 32'(game_state), 32'd1);
    chk("t1_dir",   32'(direction),  32'd4);
    n_upd = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      chk("t1_update", 32'(update), (k % 8 == 0) ? 32'd1 : 32'd0);
      if (update === 1'b1) n_upd++;
      idle();
      if (update === 1'b1) n_upd++;
    end
    chk("t1_pulses", 32'(n_upd), 32'd3);

    // 2: reversal rejection
    cyc(1'b0, 1'b0, 3'd3, 2'b00);
    cyc(1'b0, 1'b0, 3'd1, 2'b00);
    repeat (8) tick();
    chk("t2_dir_up", 32'(direction), 32'd1);
    cyc(1'b0, 1'b0, 3'd4, 2'b00);
    repeat (8) tick();
    chk("t2_dir_right", 32'(direction), 32'd4);
    cyc(1'b0, 1'b0, 3'd3, 2'b00);
    repeat (8) tick();
    chk("t2_left_rejected", 32'(direction), 32'd4);

    // 3: apple counting, each apple held five cycles
    repeat (4) begin
      repeat (5) cyc(1'b0, 1'b0, 3'd0, 2'b10);
      idle();
    end
    chk("t3_score", 32'(score), 32'd4);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      seen = (update === 1'b1) ? 1 : 0;
      idle();
    end
    chk("t3_sync", 32'(seen), 32'd1);
    n = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      n++;
      seen = (update === 1'b1) ? 1 : 0;
      idle();
    end
    chk("t3_period", 32'(n), 32'(EXP_P_AFTER4));

    // 4: wall collision on the completing tick
    repeat (EXP_P_AFTER4 - 1) tick();
    cyc(1'b1, 1'b0, 3'd0, 2'b01);
    chk("t4_no_update", 32'(update), 32'd0);
    chk("t4_over", 32'(game_state), 32'd3);
    idle();
    press();
    chk("t4_btn_ignored", 32'(game_state), 32'd3);
    for (int i = 1; i <= int'(GO_FRAMES); i++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      if (i == int'(GO_FRAMES) - 1) chk("t4_still_over", 32'(game_state), 32'd3);
      idle();
    end
    chk("t4_back_start", 32'(game_state), 32'd0);
    chk("t4_dir_right", 32'(direction), 32'd4);

    // 5: pause freezes the frame counter
    press();
    repeat (5) tick();
    press();
    chk("t5_paused", 32'(game_state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      chk("t5_no_update", 32'(update), 32'd0);
      idle();
    end
    press();
    chk("t5_resumed", 32'(game_state), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 2'b00);
      chk("t5_resume_step", 32'(update), (i == 3) ? 32'd1 : 32'd0);
      idle();
    end

    // score saturation
    repeat (MAX_SCORE + 5) begin
      cyc(1'b0, 1'b0, 3'd0, 2'b10);
      idle();
    end
    chk("sat_score", 32'(score), 32'(MAX_SCORE));

    // 6: async reset mid-PLAY with score 3
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    press();
    repeat (3) begin
      cyc(1'b0, 1'b0, 3'd0, 2'b10);
      idle();
    end
    repeat (3) tick();
    chk("t6_score3", 32'(score), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("t6_async");
    @(negedge clk);
    reset = 1'b0;
    idle();

    // randomized play against the model
    sb_lvl = 1'b0;
    press();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) sb_lvl = ~sb_lvl;
      ft = ($urandom_range(0, 2) == 0);
      di = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      r  = int'($urandom_range(0, 199));
      co = (r < 1) ? 2'b01 : (r < 16) ? 2'b10 : (r < 22) ? 2'b11 : 2'b00;
      cyc(ft, sb_lvl, di, co);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
